// File: rtl/updown_seq_checker.sv
// updown_seq_checker: tracks a bouncing 0..100 counter
// (up by 2, down by 1) and flags samples that break it.
module updown_seq_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic       smp_vld,
  input  logic [6:0] cnt_in,
  input  logic       err_clr,
  output logic       locked,
  output logic       dir,
  output logic [6:0] exp_val,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       period_pls
);

  typedef enum logic [1:0] {
    ACQ,
    SYNC,
    LOCK
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] anchor_q, anchor_d;
  logic       dir_d;
  logic [6:0] exp_d;
  logic [7:0] cnt_d;
  logic       viol, per;
  logic       legal, up_ok, dn_ok;
  logic [7:0] up_c, dn_c, hit, adv;

  // {dir, value} of the sample that follows v when moving in d
  function automatic logic [7:0] nxt(
    input logic [6:0] v,
    input logic       d
  );
    if (v == 7'd100) return {1'b1, 7'd99};
    if (v == 7'd0) return {1'b0, 7'd2};
    if (d) return {1'b1, v - 7'd1};
    return {1'b0, v + 7'd2};
  endfunction

  always_comb begin
    legal = cnt_in <= 7'd100;
    up_c  = nxt(anchor_q, 1'b0);
    dn_c  = nxt(anchor_q, 1'b1);
    up_ok = ~anchor_q[0] & (cnt_in == up_c[6:0]);
    dn_ok = cnt_in == dn_c[6:0];
    hit   = up_ok ? up_c : dn_c;
    adv   = nxt(cnt_in, (state_q == LOCK) ? dir : hit[7]);
  end

  always_comb begin
    state_d  = state_q;
    anchor_d = anchor_q;
    dir_d    = dir;
    exp_d    = exp_val;
    viol     = 1'b0;
    per      = 1'b0;
    if (smp_vld) begin
      unique case (state_q)
        ACQ: begin
          if (legal) begin
            anchor_d = cnt_in;
            state_d  = SYNC;
          end else begin
            viol = 1'b1;
          end
        end
        SYNC: begin
          if (!legal) begin
            viol    = 1'b1;
            state_d = ACQ;
          end else if (up_ok | dn_ok) begin
            state_d        = LOCK;
            {dir_d, exp_d} = adv;
          end else begin
            anchor_d = cnt_in;
          end
        end
        LOCK: begin
          if (cnt_in == exp_val) begin
            {dir_d, exp_d} = adv;
            // exp_val is 0 only right after the 1 at the end of the down leg
            per = cnt_in == 7'd0;
          end else begin
            viol = 1'b1;
            if (legal) begin
              anchor_d = cnt_in;
              state_d  = SYNC;
            end else begin
              state_d = ACQ;
            end
          end
        end
        default: state_d = ACQ;
      endcase
    end
  end

  always_comb begin
    if (err_clr) begin
      cnt_d = {7'd0, viol};
    end else if (viol && err_cnt != 8'hFF) begin
      cnt_d = err_cnt + 8'd1;
    end else begin
      cnt_d = err_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACQ;
      anchor_q   <= '0;
      dir        <= 1'b0;
      exp_val    <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
      period_pls <= 1'b0;
    end else begin
      state_q    <= state_d;
      anchor_q   <= anchor_d;
      dir        <= dir_d;
      exp_val    <= exp_d;
      err        <= viol;
      err_cnt    <= cnt_d;
      period_pls <= per;
    end
  end

  assign locked = state_q == LOCK;

endmodule

// File: tb/tb_updown_seq_checker.sv
// tb_updown_seq_checker: sequence-table reference model,
// per-cycle compare plus directed literal checks.
module tb_updown_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       smp_vld = 1'b0;
  logic       err_clr = 1'b0;
  logic [6:0] cnt_in = '0;
  logic       locked, dir, err, period_pls;
  logic [6:0] exp_val;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int seq[150];
  int ms = 0;
  int ma = 0;
  int me = 0;
  int mcnt = 0;
  int hit;
  int s;
  bit merr = 1'b0;
  bit mper = 1'b0;
  bit mv;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  updown_seq_checker dut (
    .clk(clk),
    .rst(rst),
    .smp_vld(smp_vld),
    .cnt_in(cnt_in),
    .err_clr(err_clr),
    .locked(locked),
    .dir(dir),
    .exp_val(exp_val),
    .err(err),
    .err_cnt(err_cnt),
    .period_pls(period_pls)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // model: ms 0=ACQ 1=SYNC 2=LOCK; me = index of expected sample
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms = 0; ma = 0; me = 0;
      merr = 0; mper = 0; mcnt = 0;
    end else begin
      mv = 0;
      mper = 0;
      if (smp_vld) begin
        s = int'(cnt_in);
        case (ms)
          0: begin
            if (s > 100) mv = 1;
            else begin ma = s; ms = 1; end
          end
          1: begin
            hit = -1;
            for (int i = 0; i < 150; i++)
              if (seq[i] == ma && seq[(i + 1) % 150] == s)
                hit = i;
            if (s > 100) begin mv = 1; ms = 0; end
            else if (hit >= 0) begin
              ms = 2; me = (hit + 2) % 150;
            end else ma = s;
          end
          default: begin
            if (s == seq[me]) begin
              mper = (s == 0);
              me = (me + 1) % 150;
            end else begin
              mv = 1;
              if (s > 100) ms = 0;
              else begin ms = 1; ma = s; end
            end
          end
        endcase
      end
      merr = mv;
      if (err_clr) mcnt = mv;
      else if (mv && mcnt < 255) mcnt++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("locked", locked, ms == 2);
      chk("err", err, merr);
      chk("err_cnt", err_cnt, mcnt);
      chk("period_pls", period_pls, mper);
      if (ms == 2) begin
        chk("dir", dir, (me > 50 || me == 0));
        chk("exp_val", exp_val, seq[me]);
      end
    end
  end

  task automatic send(input bit v, input int val, input bit clr = 0);
    @(negedge clk);
    smp_vld = v;
    cnt_in = val[6:0];
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int per_n, err_n, idx;
    for (int i = 0; i < 150; i++)
      seq[i] = (i <= 50) ? 2 * i : 150 - i;
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_dir", dir, 0);
    chk("rst_exp", exp_val, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_per", period_pls, 0);
    cmp_en = 1;
    @(negedge clk);
    rst = 0;

    per_n = 0;
    err_n = 0;
    for (int i = 0; i <= 150; i++) begin
      send(1, seq[i % 150]);
      per_n += int'(period_pls);
      err_n += int'(err);
      if (i == 0) chk("nolock_0", locked, 0);
      if (i == 1) chk("lock_2", locked, 1);
      if (i == 50) begin
        chk("dir_100", dir, 1);
        chk("exp_100", exp_val, 99);
      end
      if (i == 150) chk("dir_0", dir, 0);
    end
    chk("clean_per", per_n, 1);
    chk("clean_err", err_n, 0);

    for (int i = 1; i <= 20; i++) send(1, seq[i]);
    send(1, 40);
    chk("cor_err", err, 1);
    chk("cor_cnt", err_cnt, 1);
    chk("cor_lock", locked, 0);
    send(1, 42);
    send(1, 44);
    chk("relock", locked, 1);
    chk("relock_dir", dir, 0);
    chk("relock_cnt", err_cnt, 1);

    send(1, 101);
    chk("b101_err", err, 1);
    chk("b101_lock", locked, 0);
    send(1, 50);
    send(1, 49);
    chk("amb_dn_lock", locked, 1);
    chk("amb_dn_dir", dir, 1);
    chk("amb_dn_exp", exp_val, 48);
    send(1, 101);
    send(1, 50);
    send(1, 52);
    chk("amb_up_lock", locked, 1);
    chk("amb_up_dir", dir, 0);
    chk("amb_up_exp", exp_val, 54);
    send(1, 101);
    send(1, 51);
    chk("amb_odd_err", err, 0);
    send(1, 53);
    chk("amb_odd_lock", locked, 0);
    chk("amb_odd_err2", err, 0);

    send(1, 101);
    idx = $urandom_range(0, 149);
    err_n = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) send(0, $urandom_range(0, 127));
      else begin
        send(1, seq[idx]);
        idx = (idx + 1) % 150;
      end
      err_n += int'(err);
    end
    chk("gap_err", err_n, 0);
    chk("gap_lock", locked, 1);

    for (int n = 0; n < 500; n++) begin
      send($urandom_range(0, 3) != 0,
           ($urandom_range(0, 2) == 0) ? $urandom_range(0, 127) : seq[idx],
           $urandom_range(0, 15) == 0);
      idx = (idx + 1) % 150;
    end

    repeat (300) send(1, 127);
    chk("sat_cnt", err_cnt, 255);
    send(1, 127, 1);
    chk("clr_viol", err_cnt, 1);
    send(0, 0, 1);
    chk("clr_only", err_cnt, 0);

    send(1, 101);
    send(1, 58);
    send(1, 60);
    send(0, 0);
    chk("pre_rst_lock", locked, 1);
    chk("pre_rst_exp", exp_val, 62);
    #2 rst = 1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_dir", dir, 0);
    chk("arst_exp", exp_val, 0);
    chk("arst_err", err, 0);
    chk("arst_cnt", err_cnt, 0);
    chk("arst_per", period_pls, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    send(1, 7);
    send(1, 6);
    chk("restart_lock", locked, 1);
    chk("restart_dir", dir, 1);
    chk("restart_exp", exp_val, 5);
    send(0, 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_seq_checker.md
UPDOWN_SEQ_CHECKER -- requirements
Module: updown_seq_checker

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port smp_vld  input  1  cnt_in is a valid sample this cycle.
REQ-004 SHALL have port cnt_in  input  7  sampled value from the bouncing 0..100 counter.
REQ-005 SHALL have port err_clr  input  1  synchronous clear of err_cnt.
REQ-006 SHALL have port locked  output  1  checker is tracking the sequence.
REQ-007 SHALL have port dir  output  1  tracked direction, 0 = up, 1 = down.
REQ-008 SHALL have port exp_val  output  7  predicted next sample, valid when locked=1.
REQ-009 SHALL have port err  output  1  one-cycle pulse flagging a sequence violation.
REQ-010 SHALL have port err_cnt  output  8  violation count, saturating.
REQ-011 SHALL have port period_pls  output  1  one-cycle pulse when one full period completes.

Function
REQ-012 Legal sequence SHALL be 0,2,4,...,98,100,99,98,...,1,0,2,...: period 150 samples.
REQ-013 Successor nxt(v,d) SHALL be: v=100 -> 99, d=down; v=0 -> 2, d=up; otherwise d=up -> v+2, d=down -> v-1.
REQ-014 In up direction, only even v SHALL be legal. Any v>100 SHALL always be illegal.
REQ-015 The FSM SHALL have three states: ACQ (no anchor), SYNC (anchor held), LOCK.
REQ-016 Only cycles with smp_vld=1 SHALL advance the FSM or counters. Cycles with smp_vld=0 SHALL hold all state.
REQ-017 ACQ handling: a legal sample (<=100) SHALL become the anchor and move to SYNC. A sample >100 SHALL pulse err and stay in ACQ.
REQ-018 SYNC handling: the sample SHALL match nxt(anchor,up) (only if anchor is even) or nxt(anchor,down); on a match -> LOCK with dir set to the matching direction and exp_val=nxt(sample,dir).
REQ-019 SYNC handling on a mismatch: the sample SHALL become the new anchor and the FSM stays in SYNC. err SHALL be pulsed only if the sample is >100, and then the FSM returns to ACQ.
REQ-020 LOCK handling: sample==exp_val SHALL update exp_val/dir per REQ-013. A mismatch SHALL pulse err, increment err_cnt, clear locked, and take the sample as the anchor in SYNC, or go to ACQ if the sample is >100.
REQ-021 The anchor 0 or 100 SHALL fix the SYNC candidate set to 2 or 99 respectively.
REQ-022 err and period_pls SHALL be registered and asserted in the cycle after the offending/qualifying sample edge, high for exactly one cycle.
REQ-023 locked SHALL equal (state==LOCK), registered.
REQ-024 period_pls SHALL fire when, in LOCK, an accepted sample equals 0 and the previous accepted sample was 1, i.e. once per 150 accepted samples.
REQ-025 err_cnt SHALL saturate at 255.
REQ-026 err_clr=1 SHALL zero err_cnt in the next cycle. If err_clr coincides with a violation, the result SHALL be 1.
REQ-027 exp_val arithmetic SHALL be 7-bit. Values 101..127 SHALL never be predicted.

Reset
REQ-028 While rst=1 the block SHALL hold: state=ACQ, locked=0, dir=0, exp_val=0, err=0, err_cnt=0, period_pls=0, anchor=0.
REQ-029 rst asserted mid-operation SHALL abandon lock immediately. The first valid sample after release SHALL be treated per ACQ.

Verification
REQ-030 Case "reset then clean sequence": reset, then feed 0,2,4,...,100,99,...,1,0 with smp_vld=1 every cycle -> locked=1 one cycle after sample 2, err never set, period_pls once after the final 0.
REQ-031 Case "single-value corruption": locked stream feeds 40 where 42 is expected on the up leg -> err pulse, err_cnt=1, locked=0. Then 42,44 -> re-lock after 44 with dir=0, err_cnt still 1.
REQ-032 Case "down-leg ambiguity": feed 50 then 49 from ACQ -> lock with dir=1, exp_val=48. Feed 50 then 52 -> dir=0, exp_val=54. Feed 51 then 53 -> no lock, no err.
REQ-033 Case "boundaries": locked stream crosses 98,100,99 and 2,1,0,2 -> dir toggles at 100 and at 0, no err. Feeding 101 -> err pulse, state ACQ.
REQ-034 Case "smp_vld gaps and saturation": random smp_vld=0 gaps within a clean stream -> no err, same lock behaviour. Then 300 forced violations -> err_cnt=255. err_clr with a simultaneous violation -> err_cnt=1.
REQ-035 Case "reset mid-stream": assert rst while locked at 60 -> all outputs per REQ-028 asynchronously. Restart with 7,6 -> locked with dir=1.
